// File: rtl/float_pkg.sv
// float_pkg: shared single-precision constants, field helpers and the
// divider FSM state encoding. Imported by float_div and mant_div.
package float_pkg;

    localparam int EXP_BIAS  = 127;
    localparam int EXP_SHIFT = 23;
    localparam int EXP_W     = 8;
    localparam int MANT_W    = 23;
    localparam int SIG_W     = MANT_W + 1;   // mantissa with hidden bit
    localparam int QBITS     = 26;           // quotient bits, q[25] is integer bit
    localparam int CNT_W     = 5;            // wide enough to count QBITS iterations
    localparam int EXT_EXP_W = 10;           // signed working exponent

    localparam logic [EXP_W-1:0]            EXP_INF  = 8'hFF;
    localparam logic signed [EXT_EXP_W-1:0] BIAS_EXT = 10'(EXP_BIAS);

    // State encoding
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PREP   = 3'd1;
    localparam logic [2:0] S_DIV    = 3'd2;
    localparam logic [2:0] S_NORM   = 3'd3;
    localparam logic [2:0] S_ROUND  = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_PREP   = S_PREP,
        ST_DIV    = S_DIV,
        ST_NORM   = S_NORM,
        ST_ROUND  = S_ROUND,
        ST_FINISH = S_FINISH
    } state_t;

    function automatic logic sign_of(input logic [31:0] f);
        return f[31];
    endfunction

    function automatic logic [EXP_W-1:0] exp_of(input logic [31:0] f);
        return f[EXP_SHIFT +: EXP_W];
    endfunction

    function automatic logic [MANT_W-1:0] mant_of(input logic [31:0] f);
        return f[MANT_W-1:0];
    endfunction

endpackage

// File: rtl/mant_div.sv
// mant_div: iterative restoring divider for 24-bit significands.
// One quotient bit per cycle, QBITS cycles after load.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : start a new division (dividend/divisor captured)
//   dividend  : {1, m1}
//   divisor   : {1, m2}
//   done      : high during the final iteration cycle; q is final after that edge
//   q         : floor(2^25 * dividend / divisor)
module mant_div
    import float_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SIG_W-1:0] dividend,
    input  logic [SIG_W-1:0] divisor,
    output logic             done,
    output logic [QBITS-1:0] q
);

    // Remainder stays below 2*divisor < 2^25, so 25 bits suffice.
    logic [SIG_W:0]   rem;
    logic [SIG_W-1:0] div_r;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             ge;
    logic [SIG_W:0]   diff;

    assign ge   = rem >= {1'b0, div_r};
    assign diff = rem - {1'b0, div_r};
    assign done = busy && (cnt == CNT_W'(QBITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rem   <= '0;
            div_r <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            q     <= '0;
        end else if (load) begin
            rem   <= {1'b0, dividend};
            div_r <= divisor;
            cnt   <= '0;
            busy  <= 1'b1;
            q     <= '0;
        end else if (busy) begin
            q   <= {q[QBITS-2:0], ge};
            // Both candidates are below 2^24 before the shift, so the top
            // bit dropped here is always zero.
            rem <= ge ? {diff[SIG_W-1:0], 1'b0} : {rem[SIG_W-1:0], 1'b0};
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/float_div.sv
// float_div: sequential IEEE-754 single-precision divider,
// float_out = float_in_1 / float_in_2, round-half-up on the first
// discarded quotient bit, denormals flushed to zero, NaN/inf not special.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : request, sampled only in IDLE
//   float_in_1  : dividend, captured on the accepting edge
//   float_in_2  : divisor, captured on the accepting edge
//   float_out   : registered quotient, holds until the next result
//   ready       : result valid
//   state       : current FSM state (observability)
// Handshake: a request is accepted on any edge where state is IDLE and
// start is high; ready drops on that edge and rises on the FINISH edge
// together with the new float_out, then stays high until the next accept.
module float_div
    import float_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] float_in_1,
    input  logic [31:0] float_in_2,
    output logic [31:0] float_out,
    output logic        ready,
    output state_t      state
);

    logic [31:0]                  a_r;
    logic [31:0]                  b_r;
    logic                         sign_r;
    logic signed [EXT_EXP_W-1:0]  exp_r;
    logic [MANT_W-1:0]            mant_r;
    logic                         rbit_r;
    logic                         special_r;
    logic [31:0]                  special_val_r;

    logic                         div_load;
    logic                         div_done;
    logic [QBITS-1:0]             q;
    logic [MANT_W:0]              mant_sum;
    logic                         a_zero;
    logic                         b_zero;

    assign a_zero   = exp_of(a_r) == '0;
    assign b_zero   = exp_of(b_r) == '0;
    assign div_load = (state == ST_PREP) && !a_zero && !b_zero;
    assign mant_sum = {1'b0, mant_r} + {{MANT_W{1'b0}}, rbit_r};

    mant_div u_mant_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .dividend ({1'b1, mant_of(a_r)}),
        .divisor  ({1'b1, mant_of(b_r)}),
        .done     (div_done),
        .q        (q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            a_r           <= '0;
            b_r           <= '0;
            sign_r        <= 1'b0;
            exp_r         <= '0;
            mant_r        <= '0;
            rbit_r        <= 1'b0;
            special_r     <= 1'b0;
            special_val_r <= '0;
            float_out     <= '0;
            ready         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_r   <= float_in_1;
                        b_r   <= float_in_2;
                        ready <= 1'b0;
                        state <= ST_PREP;
                    end
                end

                ST_PREP: begin
                    sign_r    <= sign_of(a_r) ^ sign_of(b_r);
                    exp_r     <= $signed({2'b00, exp_of(a_r)})
                               - $signed({2'b00, exp_of(b_r)}) + BIAS_EXT;
                    special_r <= 1'b0;
                    // Zero/denormal divisor wins over zero dividend, so 0/0 is inf.
                    if (b_zero) begin
                        special_r     <= 1'b1;
                        special_val_r <= {sign_of(a_r) ^ sign_of(b_r), EXP_INF, {MANT_W{1'b0}}};
                        state         <= ST_FINISH;
                    end else if (a_zero) begin
                        special_r     <= 1'b1;
                        special_val_r <= {sign_of(a_r) ^ sign_of(b_r), 31'h0};
                        state         <= ST_FINISH;
                    end else begin
                        state <= ST_DIV;
                    end
                end

                ST_DIV: begin
                    if (div_done) begin
                        state <= ST_NORM;
                    end
                end

                ST_NORM: begin
                    // Quotient of two [1,2) significands lies in (0.5, 2).
                    if (q[QBITS-1]) begin
                        mant_r <= q[QBITS-2:2];
                        rbit_r <= q[1];
                    end else begin
                        mant_r <= q[QBITS-3:1];
                        rbit_r <= q[0];
                        exp_r  <= exp_r - 10'sd1;
                    end
                    state <= ST_ROUND;
                end

                ST_ROUND: begin
                    // A carry out means the significand rolled to 2.0:
                    // field becomes zero and the exponent steps up.
                    mant_r <= mant_sum[MANT_W-1:0];
                    if (mant_sum[MANT_W]) begin
                        exp_r <= exp_r + 10'sd1;
                    end
                    state <= ST_FINISH;
                end

                ST_FINISH: begin
                    if (special_r) begin
                        float_out <= special_val_r;
                    end else if (exp_r >= 10'sd255) begin
                        float_out <= {sign_r, EXP_INF, {MANT_W{1'b0}}};
                    end else if (exp_r <= 10'sd0) begin
                        float_out <= {sign_r, 31'h0};
                    end else begin
                        float_out <= {sign_r, exp_r[EXP_W-1:0], mant_r};
                    end
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_div.sv
module tb_float_div;
    import float_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] float_in_1;
    logic [31:0] float_in_2;
    logic [31:0] float_out;
    logic        ready;
    state_t      state;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    float_div dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .float_in_1 (float_in_1),
        .float_in_2 (float_in_2),
        .float_out  (float_out),
        .ready      (ready),
        .state      (state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end
    endtask

    // Reference: real-valued quotient of the significands truncated to
    // 2^-25 resolution, then normalised and rounded half-up.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        int          e1;
        int          e2;
        int          e;
        logic        s;
        longint      m1;
        longint      m2;
        longint      qv;
        longint      sig;
        longint      rb;
        logic [31:0] ev;
        logic [63:0] sv;
        s  = a[31] ^ b[31];
        e1 = int'(a[30:23]);
        e2 = int'(b[30:23]);
        if (e2 == 0) return {s, 8'hFF, 23'h0};
        if (e1 == 0) return {s, 31'h0};
        m1 = longint'({1'b1, a[22:0]});
        m2 = longint'({1'b1, b[22:0]});
        qv = (m1 * 64'sd33554432) / m2;
        e  = e1 - e2 + 127;
        if (qv >= 64'sd33554432) begin
            sig = qv / 4;
            rb  = (qv / 2) % 2;
        end else begin
            sig = qv / 2;
            rb  = qv % 2;
            e   = e - 1;
        end
        sig = sig + rb;
        if (sig >= 64'sd16777216) begin
            sig = sig / 2;
            e   = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        ev = e;
        sv = sig;
        return {s, ev[7:0], sv[22:0]};
    endfunction

    // ---------------- driver ----------------
    // poke: pulse start with junk operands while the divide is running.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input int lat, input bit poke);
        int          edges;
        logic [31:0] e_res;
        int          e_lat;
        exp_q.push_back(res);
        lat_q.push_back(lat);
        @(negedge clk);
        float_in_1 = a;
        float_in_2 = b;
        start      = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start      = 1'b0;
        float_in_1 = $urandom;
        float_in_2 = $urandom;
        check("ready_cleared", {31'b0, ready}, 32'd0);
        while (!ready && edges < 64) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (poke && (edges == 10 || edges == 20)) begin
                start      = 1'b1;
                float_in_1 = $urandom;
                float_in_2 = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        e_res = exp_q.pop_front();
        e_lat = lat_q.pop_front();
        check("latency", edges, e_lat);
        check("result", float_out, e_res);
        check("state_idle_after", 32'(state), 32'(ST_IDLE));
    endtask

    function automatic int lat_of(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'h0 || b[30:23] == 8'h0) ? 3 : 31;
    endfunction

    // ---------------- test ----------------
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] held;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 31};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 31};
        vecs[2]  = '{32'hC1000000, 32'h40000000, 32'hC0800000, 31};
        vecs[3]  = '{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 31};
        vecs[4]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 3};
        vecs[5]  = '{32'h00000000, 32'h40000000, 32'h00000000, 3};
        vecs[6]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 31};
        vecs[7]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 31};
        vecs[8]  = '{32'h80000000, 32'h00000000, 32'hFF800000, 3};
        vecs[9]  = '{32'hBF800000, 32'h00000001, 32'hFF800000, 3};
        vecs[10] = '{32'h00400000, 32'h3F800000, 32'h00000000, 3};
        vecs[11] = '{32'h3F800000, 32'hBF800000, 32'hBF800000, 31};
        vecs[12] = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 31};
        vecs[13] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 31};
        vecs[14] = '{32'h00800000, 32'h3F800000, 32'h00800000, 31};
        vecs[15] = '{32'h00800000, 32'h40000000, 32'h00000000, 31};

        // reset
        rst        = 1'b1;
        start      = 1'b0;
        float_in_1 = '0;
        float_in_2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_float_out", float_out, 32'h0);
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_state", 32'(state), 32'(ST_IDLE));

        // directed table
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 1'b0);
        end

        // result and ready hold while idle
        held = float_out;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("hold_float_out", float_out, held);
        check("hold_ready", {31'b0, ready}, 32'd1);

        // start pulses during DIV are ignored
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 31, 1'b1);
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 31, 1'b1);

        // reset in the middle of DIV, with a coincident start
        @(negedge clk);
        float_in_1 = 32'h3F800000;
        float_in_2 = 32'h3FC00000;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("mid_div_state", 32'(state), 32'(ST_DIV));
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_mid_float_out", float_out, 32'h0);
        check("rst_mid_ready", {31'b0, ready}, 32'd0);
        check("rst_mid_state", 32'(state), 32'(ST_IDLE));
        @(posedge clk);
        @(negedge clk);
        check("rst_start_dropped", 32'(state), 32'(ST_IDLE));
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 31, 1'b0);

        // randomized against the reference model
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 0) begin
                ra[30:23] = 8'($urandom_range(100, 154));
                rb[30:23] = 8'($urandom_range(100, 154));
            end
            if ($urandom_range(0, 15) == 0) ra[30:23] = 8'h0;
            if ($urandom_range(0, 15) == 0) rb[30:23] = 8'h0;
            run_op(ra, rb, model(ra, rb), lat_of(ra, rb), (i % 7) == 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
